// File: rtl/mem_req_adapter.sv
// mem_req_adapter: turns core byte/half/word loads and stores into word-wide
// cache requests, with lane selection and sign/zero extension on loads.
// Build option: define MEM_REQ_ADAPTER_SUBWORD_STORE_EN to service aligned
// byte/half stores as read-modify-write; otherwise they are rejected with err.
`timescale 1ns/1ps
module mem_req_adapter #(
    parameter int unsigned ADDR_W = 27
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_we,
    input  logic [1:0]        core_req_size,
    input  logic              core_req_unsigned,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [31:0]       core_req_wdata,
    output logic              core_resp_valid,
    output logic [31:0]       core_resp_rdata,
    output logic              core_resp_err,
    output logic [ADDR_W-1:0] cache_req_addr,
    output logic [31:0]       cache_req_data,
    output logic              cache_req_rw,
    output logic              cache_req_valid,
    input  logic [31:0]       cache_res_data,
    input  logic              cache_res_ready
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned STATE_W = 3;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SIZE_ILL  = 2'b11;

`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        RMW_RD = 3'd3,
        MERGE  = 3'd4,
        RMW_WR = 3'd5,
        RESP   = 3'd6
    } state_e;
`else
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        RESP   = 3'd6
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LANE_W-1:0]   off_q, off_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic                uns_q, uns_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                resp_valid_q, resp_valid_d;
    logic                req_valid_q, req_valid_d;
    logic                rw_q, rw_d;
    logic                ready_q, ready_d;
`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
    logic [DATA_W-1:0]   rd_word_q, rd_word_d;
`endif
    logic                misaligned_c;

    // Select the addressed lane of a cache word and extend it to 32 bits.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] word,
        input logic [LANE_W-1:0] off,
        input logic [SIZE_W-1:0] size,
        input logic              uns
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh  = word;
        res = word;
        case (size)
            SIZE_BYTE: begin
                sh  = word >> {off, 3'b000};
                res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            SIZE_HALF: begin
                sh  = word >> {off[1], 4'b0000};
                res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
    // Overwrite only the addressed byte/half lanes of the old word.
    function automatic logic [DATA_W-1:0] store_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wd,
        input logic [LANE_W-1:0] off,
        input logic [SIZE_W-1:0] size
    );
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] ins;
        mask = 32'h0000_00FF << {off, 3'b000};
        ins  = {24'h0, wd[7:0]} << {off, 3'b000};
        if (size == SIZE_HALF) begin
            mask = 32'h0000_FFFF << {off[1], 4'b0000};
            ins  = {16'h0, wd[15:0]} << {off[1], 4'b0000};
        end
        return (old & ~mask) | ins;
    endfunction
`endif

    // Alignment rule applied to the incoming request.
    assign misaligned_c = (core_req_size == SIZE_ILL) ||
                          ((core_req_size == SIZE_HALF) && core_req_addr[0]) ||
                          ((core_req_size == SIZE_WORD) && (core_req_addr[1:0] != 2'b00));

    // Next-state, captured request fields and registered output values.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        off_d     = off_q;
        size_d    = size_q;
        uns_d     = uns_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
        rd_word_d = rd_word_q;
`endif

        case (state_q)
            IDLE: begin
                if (core_req_valid && core_req_ready) begin
                    addr_d = {core_req_addr[ADDR_W-1:2], 2'b00};
                    data_d = core_req_wdata;
                    off_d  = core_req_addr[1:0];
                    size_d = core_req_size;
                    uns_d  = core_req_unsigned;
                    if (misaligned_c) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (!core_req_we) begin
                        state_d = READ;
                    end else if (core_req_size == SIZE_WORD) begin
                        state_d = WRITE;
                    end else begin
`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
                        state_d = RMW_RD;
`else
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
`endif
                    end
                end
            end
            READ: begin
                if (cache_res_ready) begin
                    state_d = RESP;
                    rdata_d = load_extract(cache_res_data, off_q, size_q, uns_q);
                    err_d   = 1'b0;
                end
            end
            WRITE: begin
                if (cache_res_ready) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
            RMW_RD: begin
                if (cache_res_ready) begin
                    state_d   = MERGE;
                    rd_word_d = cache_res_data;
                end
            end
            MERGE: begin
                state_d = RMW_WR;
                data_d  = store_merge(rd_word_q, data_q, off_q, size_q);
            end
            RMW_WR: begin
                if (cache_res_ready) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
        req_valid_d  = (state_d == READ) || (state_d == WRITE) ||
                       (state_d == RMW_RD) || (state_d == RMW_WR);
        rw_d         = (state_d == WRITE) || (state_d == RMW_WR);
`else
        req_valid_d  = (state_d == READ) || (state_d == WRITE);
        rw_d         = (state_d == WRITE);
`endif
    end

    // State and output registers; reset clears everything but ready.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            req_valid_q  <= 1'b0;
            rw_q         <= 1'b0;
            ready_q      <= 1'b1;
`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
            rd_word_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            req_valid_q  <= req_valid_d;
            rw_q         <= rw_d;
            ready_q      <= ready_d;
`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
            rd_word_q    <= rd_word_d;
`endif
        end
    end

    assign core_req_ready  = ready_q;
    assign core_resp_valid = resp_valid_q;
    assign core_resp_rdata = rdata_q;
    assign core_resp_err   = err_q;
    assign cache_req_addr  = addr_q;
    assign cache_req_data  = data_q;
    assign cache_req_rw    = rw_q;
    assign cache_req_valid = req_valid_q;

endmodule

// File: tb/tb_mem_req_adapter.sv
// Self-checking bench for mem_req_adapter: byte-addressed memory model,
// randomized loads/stores, directed literal cases and a mid-transaction reset.
`timescale 1ns/1ps
module tb_mem_req_adapter;

    localparam int unsigned ADDR_W = 27;
`ifdef MEM_REQ_ADAPTER_SUBWORD_STORE_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic              sys_clk;
    logic              rstn;
    logic              core_req_valid;
    logic              core_req_ready;
    logic              core_req_we;
    logic [1:0]        core_req_size;
    logic              core_req_unsigned;
    logic [ADDR_W-1:0] core_req_addr;
    logic [31:0]       core_req_wdata;
    logic              core_resp_valid;
    logic [31:0]       core_resp_rdata;
    logic              core_resp_err;
    logic [ADDR_W-1:0] cache_req_addr;
    logic [31:0]       cache_req_data;
    logic              cache_req_rw;
    logic              cache_req_valid;
    logic [31:0]       cache_res_data;
    logic              cache_res_ready;

    mem_req_adapter #(.ADDR_W(ADDR_W)) dut (
        .sys_clk           (sys_clk),
        .rstn              (rstn),
        .core_req_valid    (core_req_valid),
        .core_req_ready    (core_req_ready),
        .core_req_we       (core_req_we),
        .core_req_size     (core_req_size),
        .core_req_unsigned (core_req_unsigned),
        .core_req_addr     (core_req_addr),
        .core_req_wdata    (core_req_wdata),
        .core_resp_valid   (core_resp_valid),
        .core_resp_rdata   (core_resp_rdata),
        .core_resp_err     (core_resp_err),
        .cache_req_addr    (cache_req_addr),
        .cache_req_data    (cache_req_data),
        .cache_req_rw      (cache_req_rw),
        .cache_req_valid   (cache_req_valid),
        .cache_res_data    (cache_res_data),
        .cache_res_ready   (cache_res_ready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct { logic [31:0] addr; logic rw; logic [31:0] data; logic gap_after; } op_t;
    typedef struct { logic [31:0] rdata; logic err; } resp_t;

    op_t   exp_ops[$];
    resp_t exp_resp[$];
    logic [31:0] model_mem [int unsigned];
    logic [31:0] cache_mem [int unsigned];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int  cyc = 0;
    bit  chk_en = 1'b0;
    int  done_cyc = -10;
    int  gap_cyc = -10;
    int  vcount = 0;
    int  last_vcount = 0;
    bit  have_last = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    bit  resp_en = 1'b1;
    bit  spur_en = 1'b0;
    int  fixed_delay = 0;
    int  cur_delay = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned wa);
        return 32'((wa * 32'h9E37_79B1) ^ 32'h5A5A_1234);
    endfunction

    function automatic logic [31:0] model_rd(input int unsigned wa);
        if (!model_mem.exists(wa)) model_mem[wa] = init_word(wa);
        return model_mem[wa];
    endfunction

    function automatic logic [31:0] cache_rd(input int unsigned wa);
        if (!cache_mem.exists(wa)) cache_mem[wa] = init_word(wa);
        return cache_mem[wa];
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input int i);
        return 8'(w >> (8 * i));
    endfunction

    // Reference behaviour: byte-level memory semantics, pushes expected traffic.
    task automatic model_txn(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned lane, wa, nb;
        logic [31:0] w, val;
        bit misal;
        lane  = addr & 32'd3;
        wa    = addr & ~32'd3;
        nb    = 1 << size;
        misal = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && lane != 0);
        if (misal || (we && size != 2'd2 && !SUBWORD)) begin
            exp_resp.push_back('{32'h0, 1'b1});
        end else if (!we) begin
            w   = model_rd(wa);
            val = 32'h0;
            for (int i = 0; i < int'(nb); i++) val |= 32'(get_byte(w, int'(lane) + i)) << (8 * i);
            if (!uns && nb < 4 && val[8 * nb - 1]) val |= 32'hFFFF_FFFF << (8 * nb);
            exp_ops.push_back('{wa, 1'b0, 32'h0, 1'b0});
            exp_resp.push_back('{val, 1'b0});
        end else if (size == 2'd2) begin
            exp_ops.push_back('{wa, 1'b1, wdata, 1'b0});
            model_mem[wa] = wdata;
            exp_resp.push_back('{32'h0, 1'b0});
        end else begin
            w = model_rd(wa);
            for (int i = 0; i < int'(nb); i++) begin
                w &= ~(32'hFF << (8 * (int'(lane) + i)));
                w |= 32'(get_byte(wdata, i)) << (8 * (int'(lane) + i));
            end
            exp_ops.push_back('{wa, 1'b0, 32'h0, 1'b1});
            exp_ops.push_back('{wa, 1'b1, w, 1'b0});
            model_mem[wa] = w;
            exp_resp.push_back('{32'h0, 1'b0});
        end
    endtask

    // Present one request for a cycle, then wait for its response; starts at a negedge.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        core_req_valid    = 1'b1;
        core_req_we       = we;
        core_req_size     = size;
        core_req_unsigned = uns;
        core_req_addr     = ADDR_W'(addr);
        core_req_wdata    = wdata;
        @(negedge sys_clk);
        core_req_valid    = 1'b0;
        core_req_we       = 1'($urandom);
        core_req_size     = 2'($urandom);
        core_req_unsigned = 1'($urandom);
        core_req_addr     = ADDR_W'($urandom);
        core_req_wdata    = $urandom;
        for (int i = 0; i < 60 && exp_resp.size() != 0; i++) @(negedge sys_clk);
        if (exp_resp.size() != 0) begin
            check("resp_timeout", 32'(exp_resp.size()), 32'h0);
            exp_resp.delete();
            exp_ops.delete();
        end
        check("ops_left_after_resp", 32'(exp_ops.size()), 32'h0);
        check("ready_after_resp", 32'(core_req_ready), 32'h1);
        exp_ops.delete();
    endtask

    task automatic preload(input int unsigned wa, input logic [31:0] w);
        model_mem[wa] = w;
        cache_mem[wa] = w;
    endtask

    // Cache model: random latency completion pulses plus optional spurious pulses.
    initial begin
        int cnt;
        logic [31:0] word;
        cnt = 0;
        cache_res_ready = 1'b0;
        cache_res_data  = 32'h0;
        forever begin
            @(negedge sys_clk);
            if (cache_res_ready) begin
                cache_res_ready = 1'b0;
                cnt = 0;
                cache_res_data = $urandom;
            end else if (cache_req_valid && resp_en) begin
                cnt++;
                if (cnt >= cur_delay) begin
                    cache_res_ready = 1'b1;
                    word = cache_rd(32'(cache_req_addr));
                    if (cache_req_rw) cache_mem[32'(cache_req_addr)] = cache_req_data;
                    cache_res_data = word;
                    cur_delay = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
                end else begin
                    cache_res_data = $urandom;
                end
            end else begin
                cnt = 0;
                cache_res_data = $urandom;
                if (spur_en && !cache_req_valid && $urandom_range(0, 3) == 0) cache_res_ready = 1'b1;
            end
        end
    end

    // Compare process: checks every cycle against the expected traffic queues.
    initial begin
        forever begin
            @(negedge sys_clk);
            #1;
            cyc++;
            if (chk_en) begin
                if (core_req_valid && core_req_ready && exp_ops.size() == 0) done_cyc = cyc;
                if (cache_req_valid) begin
                    vcount++;
                    if (exp_ops.size() == 0) begin
                        check("cache_req_unexpected", 32'h1, 32'h0);
                    end else begin
                        check("cache_req_addr", 32'(cache_req_addr), exp_ops[0].addr);
                        check("cache_req_rw", 32'(cache_req_rw), 32'(exp_ops[0].rw));
                        if (exp_ops[0].rw) check("cache_req_data", cache_req_data, exp_ops[0].data);
                        if (cache_res_ready) begin
                            if (exp_ops[0].gap_after) gap_cyc = cyc;
                            void'(exp_ops.pop_front());
                            if (exp_ops.size() == 0) done_cyc = cyc;
                            last_vcount = vcount;
                            vcount = 0;
                        end
                    end
                end else begin
                    vcount = 0;
                end
                if (cyc == gap_cyc + 1) check("merge_gap_valid_low", 32'(cache_req_valid), 32'h0);
                if (cyc == gap_cyc + 2) check("rmw_wr_valid_high", 32'(cache_req_valid), 32'h1);
                if (core_resp_valid) begin
                    if (exp_resp.size() == 0) begin
                        check("resp_unexpected", 32'h1, 32'h0);
                    end else begin
                        check("resp_rdata", core_resp_rdata, exp_resp[0].rdata);
                        check("resp_err", 32'(core_resp_err), 32'(exp_resp[0].err));
                        check("resp_latency", 32'(cyc), 32'(done_cyc + 1));
                        check("ready_low_in_resp", 32'(core_req_ready), 32'h0);
                        last_rdata = exp_resp[0].rdata;
                        have_last  = 1'b1;
                        void'(exp_resp.pop_front());
                    end
                end else if (have_last) begin
                    check("rdata_hold", core_resp_rdata, last_rdata);
                end
            end
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata;

        rstn              = 1'b0;
        core_req_valid    = 1'b0;
        core_req_we       = 1'b0;
        core_req_size     = 2'b00;
        core_req_unsigned = 1'b0;
        core_req_addr     = '0;
        core_req_wdata    = 32'h0;
        repeat (3) @(negedge sys_clk);
        rstn = 1'b1;
        @(negedge sys_clk);

        // Reset state.
        check("rst_ready", 32'(core_req_ready), 32'h1);
        check("rst_resp_valid", 32'(core_resp_valid), 32'h0);
        check("rst_resp_rdata", core_resp_rdata, 32'h0);
        check("rst_resp_err", 32'(core_resp_err), 32'h0);
        check("rst_cache_valid", 32'(cache_req_valid), 32'h0);
        check("rst_cache_addr", 32'(cache_req_addr), 32'h0);
        check("rst_cache_data", cache_req_data, 32'h0);
        check("rst_cache_rw", 32'(cache_req_rw), 32'h0);
        chk_en = 1'b1;

        // Word load with a 5-cycle cache latency.
        preload(32'h100, 32'hDEAD_BEEF);
        fixed_delay = 5; cur_delay = 5;
        exp_ops.push_back('{32'h100, 1'b0, 32'h0, 1'b0});
        exp_resp.push_back('{32'hDEAD_BEEF, 1'b0});
        run_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        check("word_load_valid_cycles", 32'(last_vcount), 32'd5);

        // Signed and unsigned byte loads from lane 3.
        fixed_delay = 0; cur_delay = 2;
        preload(32'h100, 32'h80FF_0011);
        exp_ops.push_back('{32'h100, 1'b0, 32'h0, 1'b0});
        exp_resp.push_back('{32'hFFFF_FF80, 1'b0});
        run_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        exp_ops.push_back('{32'h100, 1'b0, 32'h0, 1'b0});
        exp_resp.push_back('{32'h0000_0080, 1'b0});
        run_txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);

        // Byte store into lane 2.
        preload(32'h200, 32'h1122_3344);
        if (SUBWORD) begin
            exp_ops.push_back('{32'h200, 1'b0, 32'h0, 1'b1});
            exp_ops.push_back('{32'h200, 1'b1, 32'h11AB_3344, 1'b0});
            exp_resp.push_back('{32'h0, 1'b0});
            model_mem[32'h200] = 32'h11AB_3344;
        end else begin
            exp_resp.push_back('{32'h0, 1'b1});
        end
        run_txn(1'b1, 2'b00, 1'b0, 32'h202, 32'h0000_00AB);
        if (SUBWORD) check("byte_store_cache_word", cache_rd(32'h200), 32'h11AB_3344);
        else         check("byte_store_cache_word", cache_rd(32'h200), 32'h1122_3344);

        // Rejected requests: misaligned word and illegal size.
        exp_resp.push_back('{32'h0, 1'b1});
        run_txn(1'b0, 2'b10, 1'b0, 32'h105, 32'h0);
        exp_resp.push_back('{32'h0, 1'b1});
        run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);

        // Randomized traffic against the byte-level model.
        spur_en = 1'b1;
        for (int n = 0; n < 250; n++) begin
            we    = 1'($urandom);
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom);
            addr  = 32'h100 + $urandom_range(0, 63);
            wdata = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            model_txn(we, size, uns, addr, wdata);
            run_txn(we, size, uns, addr, wdata);
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
        end
        spur_en = 1'b0;

        // Reset in the middle of a READ, then spurious completions while idle.
        resp_en = 1'b0;
        exp_ops.push_back('{32'h100, 1'b0, 32'h0, 1'b0});
        core_req_valid    = 1'b1;
        core_req_we       = 1'b0;
        core_req_size     = 2'b10;
        core_req_unsigned = 1'b0;
        core_req_addr     = ADDR_W'(32'h100);
        @(negedge sys_clk);
        core_req_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("mid_read_valid", 32'(cache_req_valid), 32'h1);
        chk_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rst_async_valid_drop", 32'(cache_req_valid), 32'h0);
        check("rst_async_resp_valid", 32'(core_resp_valid), 32'h0);
        exp_ops.delete();
        exp_resp.delete();
        have_last = 1'b0;
        gap_cyc = -10;
        @(negedge sys_clk);
        @(negedge sys_clk);
        rstn = 1'b1;
        resp_en = 1'b1;
        spur_en = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            check("post_rst_ready", 32'(core_req_ready), 32'h1);
        end
        spur_en = 1'b0;
        check("post_rst_rdata", core_resp_rdata, 32'h0);

        // Normal operation resumes after reset.
        model_txn(1'b0, 2'b01, 1'b0, 32'h112, 32'h0);
        run_txn(1'b0, 2'b01, 1'b0, 32'h112, 32'h0);

        repeat (3) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
